// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_ctrl                                                     |
// | Purpose  : Pipeline hazard unit with forwarding, load-use stall, branch    |
// |            flush, memory-wait freeze with timeout and perf counters.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module hazard_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Ra1D,
    input  logic [4:0]  Ra2D,
    input  logic [4:0]  Ra1E,
    input  logic [4:0]  Ra2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic        mem_busy,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mem_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [1:0] c_RUN  = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_ERR  = 2'd2;

    localparam logic [7:0]  c_TIMEOUT = 8'(TIMEOUT);
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [1:0]  r_state;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic w_lw_hazard;
    logic w_freeze;
    logic w_flush_take;

    function automatic logic [1:0] fwd_sel(input logic [4:0] ra, input logic we_m,
                                           input logic [4:0] rd_m, input logic we_w,
                                           input logic [4:0] rd_w);
        if (we_m && (rd_m != 5'd0) && (rd_m == ra))
            return 2'b10;
        else if (we_w && (rd_w != 5'd0) && (rd_w == ra))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_lw_hazard  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                          ((RdE == Ra1D) || (RdE == Ra2D));
    assign w_freeze     = mem_busy || (r_state == c_ERR);
    assign w_flush_take = !rst && !w_freeze && PCSrcE;

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            ForwardAE = fwd_sel(Ra1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwd_sel(Ra2E, RegWriteM, RdM, RegWriteW, RdW);
            // A frozen pipeline must not lose a pending branch, so PCSrcE waits.
            if (w_freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (w_lw_hazard) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            case (r_state)
                c_RUN: begin
                    if (mem_busy) begin
                        r_state    <= c_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                c_WAIT: begin
                    if (!mem_busy) begin
                        r_state    <= c_RUN;
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt + 8'd1 == c_TIMEOUT) begin
                        r_state <= c_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                c_ERR:   r_state <= c_ERR;
                default: r_state <= c_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (StallF && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_flush_take && (r_flush_cnt != c_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign mem_err   = (r_state == c_ERR);
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hazard_ctrl                                                  |
// | Purpose  : Self-checking bench for hazard_ctrl against a behavioural model.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl;

    localparam int c_TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic [4:0]  Ra1D, Ra2D, Ra1E, Ra2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE;
    logic        mem_busy;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        mem_err;
    logic [15:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: consecutive-busy run length, sticky error, counters.
    int m_busy_run;
    bit m_err;
    int m_stall;
    int m_flush;

    hazard_ctrl #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .mem_busy(mem_busy),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] exp_fwd(input logic [4:0] ra);
        if (rst) return 2'b00;
        if (RegWriteM && RdM != 0 && RdM == ra) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == ra) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF, StallD, StallE, StallM, FlushD, FlushE}
    function automatic logic [5:0] exp_ctrl();
        bit lw;
        lw = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Ra1D || RdE == Ra2D);
        if (rst)               return 6'b0000_11;
        if (mem_busy || m_err) return 6'b1111_00;
        if (PCSrcE)            return 6'b0000_11;
        if (lw)                return 6'b1100_01;
        return 6'b0000_00;
    endfunction

    function automatic logic [5:0] act_ctrl();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE};
    endfunction

    // Advance one edge, updating the model from the inputs seen at that edge.
    task automatic tick();
        logic [5:0] c;
        bit frz;
        c   = exp_ctrl();
        frz = mem_busy || m_err;
        @(posedge clk);
        if (rst) begin
            m_err = 0; m_busy_run = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (c[5] && m_stall < 16'hFFFF) m_stall++;
            if (!frz && PCSrcE && m_flush < 16'hFFFF) m_flush++;
            if (!m_err) begin
                if (mem_busy) begin
                    m_busy_run++;
                    if (m_busy_run == c_TIMEOUT) m_err = 1;
                end else begin
                    m_busy_run = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; Ra1D = 0; Ra2D = 0; Ra1E = 0; Ra2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; mem_busy = 1; PCSrcE = 1; RegWriteM = 1; RdM = 3; Ra1E = 3; Ra2E = 3;
        ResultSrcE = 2'b01; RdE = 4; Ra1D = 4;
        #1;
        checks++;
        if (act_ctrl() !== 6'b0000_11) begin
            errors++; $display("FAIL reset_ctrl: got %b expected %b", act_ctrl(), 6'b0000_11);
        end
        checks++;
        if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
            errors++; $display("FAIL reset_fwd: got %b/%b expected 00/00", ForwardAE, ForwardBE);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (mem_err !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got err=%b stall=%0d flush=%0d expected 0/0/0",
                     mem_err, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_forwarding();
        logic [1:0] exp_tbl [3] = '{2'b10, 2'b01, 2'b00};
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            RegWriteM = 1; RdM = (k == 0) ? 5'd5 : 5'd0;
            RegWriteW = 1; RdW = 5; Ra1E = (k == 2) ? 5'd0 : 5'd5;
            #1;
            checks++;
            if (ForwardAE !== exp_tbl[k]) begin
                errors++; $display("FAIL fwd_case%0d: got %b expected %b", k, ForwardAE, exp_tbl[k]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
            Ra1E = 5'($urandom_range(0, 3)); Ra2E = 5'($urandom_range(0, 3));
            #1;
            checks++;
            if (ForwardAE !== exp_fwd(Ra1E) || ForwardBE !== exp_fwd(Ra2E)) begin
                errors++;
                $display("FAIL fwd_rand: got %b/%b expected %b/%b", ForwardAE, ForwardBE,
                         exp_fwd(Ra1E), exp_fwd(Ra2E));
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ResultSrcE = 2'b01; RdE = 7; Ra2D = 7; Ra1D = 2;
        #1;
        checks++;
        if (act_ctrl() !== 6'b1100_01) begin
            errors++; $display("FAIL load_use_ctrl: got %b expected %b", act_ctrl(), 6'b1100_01);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'd1 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL load_use_cnt: got %0d/%0d expected 1/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_priority();
        do_reset();
        ResultSrcE = 2'b01; RdE = 7; Ra2D = 7; PCSrcE = 1;
        #1;
        checks++;
        if (act_ctrl() !== 6'b0000_11) begin
            errors++; $display("FAIL priority_ctrl: got %b expected %b", act_ctrl(), 6'b0000_11);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd1) begin
            errors++; $display("FAIL priority_cnt: got %0d/%0d expected 0/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_short_wait();
        do_reset();
        mem_busy = 1; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (act_ctrl() !== 6'b1111_00) begin
                errors++; $display("FAIL short_wait_freeze%0d: got %b expected %b", i, act_ctrl(), 6'b1111_00);
            end
            tick();
        end
        mem_busy = 0;
        #1;
        // The branch held through the freeze now fires.
        checks++;
        if (act_ctrl() !== 6'b0000_11 || mem_err !== 1'b0 || stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL short_wait_exit: got ctrl=%b err=%b stall=%0d expected 000011/0/3",
                     act_ctrl(), mem_err, stall_cnt);
        end
        tick();
        PCSrcE = 0;
        tick();
        checks++;
        if (mem_err !== 1'b0 || flush_cnt !== 16'd1) begin
            errors++; $display("FAIL short_wait_run: got err=%b flush=%0d expected 0/1", mem_err, flush_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_busy = 1;
        for (int i = 1; i <= c_TIMEOUT; i++) begin
            tick();
            checks++;
            if (mem_err !== (i == c_TIMEOUT)) begin
                errors++; $display("FAIL timeout_edge%0d: got err=%b expected %b", i, mem_err, i == c_TIMEOUT);
            end
        end
        mem_busy = 0; PCSrcE = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (mem_err !== 1'b1 || act_ctrl() !== 6'b1111_00) begin
                errors++; $display("FAIL timeout_sticky%0d: got err=%b ctrl=%b expected 1/111100", i, mem_err, act_ctrl());
            end
            tick();
        end
        do_reset();
        checks++;
        if (mem_err !== 1'b0 || act_ctrl() !== 6'b0000_00) begin
            errors++; $display("FAIL timeout_clear: got err=%b ctrl=%b expected 0/000000", mem_err, act_ctrl());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 29) == 0);
            Ra1D       = 5'($urandom_range(0, 3)); Ra2D = 5'($urandom_range(0, 3));
            Ra1E       = 5'($urandom_range(0, 3)); Ra2E = 5'($urandom_range(0, 3));
            RdE        = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW        = 5'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom); RegWriteW = 1'($urandom);
            ResultSrcE = 2'($urandom);
            PCSrcE     = ($urandom_range(0, 3) == 0);
            mem_busy   = ($urandom_range(0, 2) == 0);
            #1;
            checks++;
            if (act_ctrl() !== exp_ctrl() || ForwardAE !== exp_fwd(Ra1E) || ForwardBE !== exp_fwd(Ra2E)) begin
                errors++;
                $display("FAIL rand_comb%0d: got ctrl=%b fa=%b fb=%b expected ctrl=%b fa=%b fb=%b", i,
                         act_ctrl(), ForwardAE, ForwardBE, exp_ctrl(), exp_fwd(Ra1E), exp_fwd(Ra2E));
            end
            checks++;
            if (mem_err !== m_err || stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
                errors++;
                $display("FAIL rand_state%0d: got err=%b stall=%0d flush=%0d expected %b/%0d/%0d", i,
                         mem_err, stall_cnt, flush_cnt, m_err, m_stall, m_flush);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_busy = 1;
        for (int i = 0; i < 65540; i++) tick();
        checks++;
        if (stall_cnt !== 16'hFFFF || m_stall != 16'hFFFF) begin
            errors++; $display("FAIL sat_stall: got %h expected FFFF", stall_cnt);
        end
        rst = 1;
        #1;
        checks++;
        if (FlushD !== 1'b1 || FlushE !== 1'b1 || StallF !== 1'b0) begin
            errors++; $display("FAIL sat_rst_ctrl: got ctrl=%b expected 000011", act_ctrl());
        end
        tick();
        rst = 0; mem_busy = 0;
        #1;
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL sat_rst_state: got stall=%0d flush=%0d err=%b expected 0/0/0",
                     stall_cnt, flush_cnt, mem_err);
        end
    endtask

    initial begin
        m_busy_run = 0; m_err = 0; m_stall = 0; m_flush = 0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_forwarding();
        test_load_use();
        test_priority();
        test_short_wait();
        test_timeout();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
